// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for a single-port register SRAM: port A has fixed priority and port B is
// guaranteed a slot after MAX_WAIT denials. Optional grant statistics: define SRAM_ARB_STATS_EN.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_a_req,
  input  logic                  i_a_write,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [31:0]           i_a_wdata,
  output logic                  o_a_gnt,
  output logic                  o_a_rvalid,
  output logic [31:0]           o_a_rdata,
  input  logic                  i_b_req,
  input  logic                  i_b_write,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [31:0]           i_b_wdata,
  output logic                  o_b_gnt,
  output logic                  o_b_rvalid,
  output logic [31:0]           o_b_rdata,
`ifdef SRAM_ARB_STATS_EN
  output logic [15:0]           o_a_gnt_cnt,
  output logic [15:0]           o_b_gnt_cnt,
  output logic [15:0]           o_conflict_cnt,
`endif
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_write,
  output logic [31:0]           o_sram_wdata,
  input  logic [31:0]           i_sram_rdata
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;
  logic       force_b;
  logic       a_gnt;
  logic       b_gnt;

  // Grants are held low combinationally while reset is asserted so nothing reaches the SRAM.
  always_comb begin
    force_b = (wait_cnt == MaxWait);
    b_gnt   = i_rst_n && i_b_req && (force_b || !i_a_req);
    a_gnt   = i_rst_n && i_a_req && !b_gnt;
  end

  assign o_a_gnt = a_gnt;
  assign o_b_gnt = b_gnt;

  always_comb begin
    o_sram_addr  = '0;
    o_sram_write = 1'b0;
    o_sram_wdata = '0;
    if (b_gnt) begin
      o_sram_addr  = i_b_addr;
      o_sram_write = i_b_write;
      o_sram_wdata = i_b_wdata;
    end else if (a_gnt) begin
      o_sram_addr  = i_a_addr;
      o_sram_write = i_a_write;
      o_sram_wdata = i_a_wdata;
    end
  end

  // Denial counter for B; any cycle B is not waiting (granted or idle) starts it over.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
    end else if (i_b_req && !b_gnt) begin
      if (wait_cnt != MaxWait) wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_a_rvalid <= 1'b0;
      o_a_rdata  <= '0;
      o_b_rvalid <= 1'b0;
      o_b_rdata  <= '0;
    end else begin
      o_a_rvalid <= a_gnt && !i_a_write;
      o_b_rvalid <= b_gnt && !i_b_write;
      if (a_gnt && !i_a_write) o_a_rdata <= i_sram_rdata;
      if (b_gnt && !i_b_write) o_b_rdata <= i_sram_rdata;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_a_gnt_cnt    <= '0;
      o_b_gnt_cnt    <= '0;
      o_conflict_cnt <= '0;
    end else begin
      if (a_gnt && o_a_gnt_cnt != 16'hFFFF) o_a_gnt_cnt <= o_a_gnt_cnt + 16'd1;
      if (b_gnt && o_b_gnt_cnt != 16'hFFFF) o_b_gnt_cnt <= o_b_gnt_cnt + 16'd1;
      if (i_a_req && i_b_req && o_conflict_cnt != 16'hFFFF)
        o_conflict_cnt <= o_conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
